// File: rtl/gpk_carry_chain_pkg.sv
// gpk_pkg: shared types and helpers for the GPK carry chain.
//   state_t    - frame tracking state (IDLE: no frame open, BUSY: carry register valid)
//   gpk_bit_t  - one bit's generate/propagate/kill triple
//   gpk_legal  - true when exactly one of g/p/k is set
package gpk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic g;
        logic p;
        logic k;
    } gpk_bit_t;

    // XOR of three bits is 1 for one or three set; exclude the all-set case.
    function automatic logic gpk_legal(gpk_bit_t b);
        return (b.g ^ b.p ^ b.k) & ~(b.g & b.p & b.k);
    endfunction

endpackage

// File: rtl/gpk_carry_chain_if.sv
// gpk_carry_chain_if: beat-in / result-out handshake bundle for gpk_carry_chain.
//   in_valid/in_ready        - input beat handshake
//   in_g/in_p/in_k           - per-bit generate/propagate/kill vectors
//   in_first/in_last/cin     - frame delimiters and frame carry-in
//   out_valid/out_ready      - result handshake
//   out_c/out_cout           - carry into each bit, carry out of the beat
//   out_err/out_last         - per-beat error flag, copy of in_last
// master drives beats and consumes results; slave is the carry chain.
interface gpk_carry_chain_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_g;
    logic [WIDTH-1:0] in_p;
    logic [WIDTH-1:0] in_k;
    logic             in_first;
    logic             in_last;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_c;
    logic             out_cout;
    logic             out_err;
    logic             out_last;

    modport master (
        output in_valid, in_g, in_p, in_k, in_first, in_last, cin, out_ready,
        input  in_ready, out_valid, out_c, out_cout, out_err, out_last
    );

    modport slave (
        input  in_valid, in_g, in_p, in_k, in_first, in_last, cin, out_ready,
        output in_ready, out_valid, out_c, out_cout, out_err, out_last
    );
endinterface

// File: rtl/gpk_carry_chain_ripple.sv
// gpk_beat_ripple: combinational carry ripple across one WIDTH-bit beat.
//   c0   in   carry into bit 0
//   g/p/k in  per-bit generate/propagate/kill
//   c    out  carry into each bit (c[0] = c0)
//   cout out  carry out of bit WIDTH-1
//   err  out  some bit did not have exactly one of g/p/k set
// Illegally encoded bits are resolved as kill.
module gpk_beat_ripple
    import gpk_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             c0,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] c,
    output logic             cout,
    output logic             err
);

    always_comb begin
        logic     carry;
        gpk_bit_t b;
        carry = c0;
        err   = 1'b0;
        c     = '0;
        b     = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            c[i] = carry;
            b    = '{g: g[i], p: p[i], k: k[i]};
            if (!gpk_legal(b)) begin
                err   = 1'b1;
                carry = 1'b0;
            end else begin
                // A legal kill bit has g=p=0, so this also yields 0 for kill.
                carry = b.g | (b.p & carry);
            end
        end
        cout = carry;
    end

endmodule

// File: rtl/gpk_carry_chain.sv
// gpk_carry_chain: streaming carry resolver for framed GPK beats.
//   clk  in  clock, all state on rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of gpk_carry_chain_if (beat in, result out)
// Parameters:
//   WIDTH  bits per beat
//   PIPE   1 = registered result (1-cycle latency), 0 = combinational pass-through
// Tracks frame state and the running carry between beats; per-beat error
// covers illegal g/p/k encodings, a first beat while a frame is open, and a
// non-first beat with no frame open.
module gpk_carry_chain
    import gpk_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter bit          PIPE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    gpk_carry_chain_if.slave      bus
);

    state_t           state_q;
    state_t           state_n;
    logic             carry_q;
    logic             carry_n;
    logic             c0;
    logic             proto_err;
    logic             rip_err;
    logic             beat_err;
    logic             beat_cout;
    logic [WIDTH-1:0] beat_c;
    logic             accept;

    always_comb begin
        c0 = 1'b0;
        if (bus.in_first) begin
            c0 = bus.cin;
        end else if (state_q == BUSY) begin
            c0 = carry_q;
        end
    end

    // First beat abandons an open frame; non-first beat has no frame to join.
    assign proto_err = bus.in_first ? (state_q == BUSY) : (state_q == IDLE);
    assign beat_err  = proto_err | rip_err;
    assign accept    = bus.in_valid & bus.in_ready;

    gpk_beat_ripple #(
        .WIDTH(WIDTH)
    ) u_ripple (
        .c0   (c0),
        .g    (bus.in_g),
        .p    (bus.in_p),
        .k    (bus.in_k),
        .c    (beat_c),
        .cout (beat_cout),
        .err  (rip_err)
    );

    always_comb begin
        state_n = state_q;
        carry_n = carry_q;
        if (accept) begin
            if (bus.in_last) begin
                state_n = IDLE;
                carry_n = 1'b0;
            end else begin
                state_n = BUSY;
                carry_n = beat_cout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_n;
            carry_q <= carry_n;
        end
    end

    if (PIPE) begin : g_pipe
        logic             valid_q;
        logic [WIDTH-1:0] c_q;
        logic             cout_q;
        logic             err_q;
        logic             last_q;

        // Data registers only load on accept, so they hold while stalled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                c_q     <= '0;
                cout_q  <= 1'b0;
                err_q   <= 1'b0;
                last_q  <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                c_q     <= beat_c;
                cout_q  <= beat_cout;
                err_q   <= beat_err;
                last_q  <= bus.in_last;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end

        assign bus.in_ready  = ~valid_q | bus.out_ready;
        assign bus.out_valid = valid_q;
        assign bus.out_c     = c_q;
        assign bus.out_cout  = cout_q;
        assign bus.out_err   = err_q;
        assign bus.out_last  = last_q;
    end else begin : g_comb
        assign bus.in_ready  = bus.out_ready;
        assign bus.out_valid = bus.in_valid;
        assign bus.out_c     = beat_c;
        assign bus.out_cout  = beat_cout;
        assign bus.out_err   = beat_err;
        assign bus.out_last  = bus.in_last;
    end

endmodule

// File: tb/tb_gpk_carry_chain.sv
// tb_gpk_carry_chain: self-checking bench for gpk_carry_chain (WIDTH=8, PIPE=1).
// Reference model maps each legal g/p/k bit to a pair of operand bits
// (g: 1+1, p: 1+0, k: 0+0), adds them with the beat carry-in, and recovers
// every carry as sum ^ a ^ b. Expected results are queued in acceptance order.
module tb_gpk_carry_chain;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gpk_carry_chain_if #(.WIDTH(W)) bus ();

    gpk_carry_chain #(
        .WIDTH(W),
        .PIPE (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] c;
        logic         cout;
        logic         err;
        logic         last;
    } exp_t;

    exp_t        expq[$];
    bit          m_open;
    logic        m_carry;
    int unsigned n_checks;
    int unsigned n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model_beat(input logic [W-1:0] g, input logic [W-1:0] p,
                                        input logic [W-1:0] k, input logic first,
                                        input logic last, input logic cin);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bad;
        logic         c0;
        logic [W:0]   s;
        logic [W:0]   cv;
        exp_t         e;
        int           n;
        a   = '0;
        b   = '0;
        bad = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            n = int'(g[i]) + int'(p[i]) + int'(k[i]);
            if (n != 1) bad = 1'b1;
            else if (g[i]) begin
                a[i] = 1'b1;
                b[i] = 1'b1;
            end else if (p[i]) a[i] = 1'b1;
        end
        if (first) c0 = cin;
        else if (m_open) c0 = m_carry;
        else c0 = 1'b0;
        s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c0};
        cv     = s ^ {1'b0, a} ^ {1'b0, b};
        e.c    = cv[W-1:0];
        e.cout = cv[W];
        e.err  = bad | (first && m_open) | (!first && !m_open);
        e.last = last;
        if (last) begin
            m_open  = 1'b0;
            m_carry = 1'b0;
        end else begin
            m_open  = 1'b1;
            m_carry = e.cout;
        end
        return e;
    endfunction

    // Called just after a falling edge with inputs already driven: checks the
    // outputs visible now and records what the next rising edge will accept.
    task automatic tick(output bit acc);
        exp_t e;
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(expq.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(expq.size() == 0 || bus.out_ready));
        if (bus.out_valid && expq.size() != 0) begin
            e = expq[0];
            chk("out_c", 32'(bus.out_c), 32'(e.c));
            chk("out_cout", 32'(bus.out_cout), 32'(e.cout));
            chk("out_err", 32'(bus.out_err), 32'(e.err));
            chk("out_last", 32'(bus.out_last), 32'(e.last));
            if (bus.out_ready) void'(expq.pop_front());
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) expq.push_back(model_beat(bus.in_g, bus.in_p, bus.in_k,
                                           bus.in_first, bus.in_last, bus.cin));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic set_beat(input logic [W-1:0] g, input logic [W-1:0] p, input logic [W-1:0] k,
                            input logic first, input logic last, input logic cin);
        bus.in_g     = g;
        bus.in_p     = p;
        bus.in_k     = k;
        bus.in_first = first;
        bus.in_last  = last;
        bus.cin      = cin;
    endtask

    task automatic wait_accept();
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) tick(acc);
        chk("accept_timeout", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] g, input logic [W-1:0] p, input logic [W-1:0] k,
                        input logic first, input logic last, input logic cin);
        set_beat(g, p, k, first, last, cin);
        bus.in_valid = 1'b1;
        wait_accept();
    endtask

    // Directed constant check of the result currently on the output.
    task automatic expect_now(input string tag, input logic [W-1:0] c, input logic cout,
                              input logic err, input logic last);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_c"}, 32'(bus.out_c), 32'(c));
        chk({tag, "_cout"}, 32'(bus.out_cout), 32'(cout));
        chk({tag, "_err"}, 32'(bus.out_err), 32'(err));
        chk({tag, "_last"}, 32'(bus.out_last), 32'(last));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_c"}, 32'(bus.out_c), 32'd0);
        chk({tag, "_cout"}, 32'(bus.out_cout), 32'd0);
        chk({tag, "_err"}, 32'(bus.out_err), 32'd0);
        chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit            acc;
        int            frame_left;
        logic [W-1:0]  g;
        logic [W-1:0]  p;
        logic [W-1:0]  k;
        logic          first;
        logic          last;
        int unsigned   sel;

        n_checks      = 0;
        n_pass        = 0;
        m_open        = 1'b0;
        m_carry       = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_beat('0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // 0xFF + 0x01 in one beat.
        send(8'h01, 8'hFE, 8'h00, 1'b1, 1'b1, 1'b0);
        expect_now("single", 8'hFE, 1'b1, 1'b0, 1'b1);
        idle(1);

        // Two-beat frame: carry out of beat0 feeds beat1.
        send(8'h80, 8'h00, 8'h7F, 1'b1, 1'b0, 1'b0);
        expect_now("frame_b0", 8'h00, 1'b1, 1'b0, 1'b0);
        send(8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
        expect_now("frame_b1", 8'hFF, 1'b1, 1'b0, 1'b1);
        idle(1);

        // Orphan non-first beat: proves the frame closed, c0 forced to 0.
        send(8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);
        expect_now("orphan", 8'h00, 1'b0, 1'b1, 1'b1);
        idle(1);

        // Bit0 has g and p set: resolved as kill.
        send(8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1);
        expect_now("illegal", 8'h01, 1'b0, 1'b1, 1'b1);
        idle(1);

        // First beat while a frame is open.
        send(8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        expect_now("abort_b0", 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1);
        expect_now("abort_b1", 8'hFF, 1'b1, 1'b1, 1'b1);
        idle(1);

        // Backpressure: a second beat stalls for 3 cycles, then both drain once.
        bus.out_ready = 1'b0;
        send(8'h01, 8'hFE, 8'h00, 1'b1, 1'b1, 1'b0);
        set_beat(8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            chk("bp_stall_accept", 32'(acc), 32'd0);
        end
        bus.out_ready = 1'b1;
        wait_accept();
        expect_now("bp_second", 8'hFF, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("bp_drained", 32'(expq.size()), 32'd0);

        // Reset mid-frame with a result still pending.
        bus.out_ready = 1'b0;
        send(8'h80, 8'h00, 8'h7F, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        expq.delete();
        m_open  = 1'b0;
        m_carry = 1'b0;
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        send(8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
        expect_now("after_rst", 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Randomized framed traffic with backpressure and occasional faults.
        frame_left = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && $urandom_range(0, 2) != 0) begin
                if (frame_left == 0) begin
                    first      = 1'b1;
                    frame_left = int'($urandom_range(1, 4));
                end else begin
                    first = 1'b0;
                end
                last = (frame_left == 1);
                frame_left--;
                if ($urandom_range(0, 15) == 0) first = ~first;
                if ($urandom_range(0, 15) == 0) last = ~last;
                g = '0;
                p = '0;
                k = '0;
                for (int i = 0; i < int'(W); i++) begin
                    sel = $urandom_range(0, 2);
                    if (sel == 0) g[i] = 1'b1;
                    else if (sel == 1) p[i] = 1'b1;
                    else k[i] = 1'b1;
                end
                if ($urandom_range(0, 7) == 0) begin
                    sel = $urandom_range(0, W - 1);
                    k[sel] = ~k[sel];
                end
                set_beat(g, p, k, first, last, 1'($urandom_range(0, 1)));
                bus.in_valid = 1'b1;
            end
            tick(acc);
            if (acc) bus.in_valid = 1'b0;
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(4);
        chk("final_drained", 32'(expq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpk_carry_chain.md
# gpk_carry_chain

Streaming carry resolver that consumes generate/propagate/kill (GPK) vectors produced by the per-bit GPK cells and returns the carry into every bit plus the carry-out. Operands wider than one beat arrive as a framed sequence of WIDTH-bit beats; the block keeps the running carry between beats. It sits between the GPK stage and the sum/XOR stage of the multiplier's final adder, with valid/ready handshakes on both sides and an optional output register selected by PIPE.

## Interface
- WIDTH, 8, bits per beat (1..64)
- PIPE, 1, 1 = registered output stage (1-cycle latency), 0 = combinational pass-through
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_g  in  WIDTH  generate per bit
- in_p  in  WIDTH  propagate per bit
- in_k  in  WIDTH  kill per bit
- in_first  in  1  first beat of a frame
- in_last  in  1  last beat of a frame (may coincide with in_first)
- cin  in  1  frame carry-in, sampled only on a first beat
- out_valid  out  1  result offered
- out_ready  in  1  result consumed when out_valid && out_ready
- out_c  out  WIDTH  carry into bit i (out_c[0] = incoming beat carry)
- out_cout  out  1  carry out of bit WIDTH-1
- out_err  out  1  protocol/encoding error on this beat
- out_last  out  1  copy of in_last for this beat

## Operation
- States: IDLE (no frame open), BUSY (frame open, carry register valid).
- Beat carry-in c0: cin if in_first; carry register if BUSY and not in_first; 0 otherwise.
- Ripple within beat: c[i+1] = g[i] | (p[i] & c[i]); kill bits force c[i+1] = 0; out_cout = c[WIDTH].
- Encoding check: each bit must have exactly one of g/p/k set; any violation treats that bit as kill and sets out_err for the beat.
- Transitions on accepted beat: last -> IDLE; first or BUSY without last -> BUSY, carry register <= out_cout.
- in_first while BUSY: open frame abandoned, new frame starts with cin, out_err = 1 on that beat.
- Non-first beat while IDLE: accepted, c0 = 0, out_err = 1; state follows in_last as above.
- out_err is per beat, not sticky.

## Timing
- Reset values: out_valid 0, out_c 0, out_cout 0, out_err 0, out_last 0, carry register 0, state IDLE; in_ready 1 when PIPE=1, follows out_ready when PIPE=0.
- PIPE=1: result appears on the cycle after acceptance; in_ready = !out_valid || out_ready (full throughput, one beat per cycle); outputs held stable while out_valid && !out_ready.
- PIPE=0: outputs combinational from inputs; out_valid = in_valid, in_ready = out_ready; state/carry update on the accepting edge only.
- No beat is lost or duplicated under any backpressure pattern.
- Reset asserted mid-frame: pending output dropped, state IDLE immediately (asynchronously); next beat must carry in_first.

## Structure
- Package gpk_pkg: state enum (IDLE, BUSY), gpk_bit_t struct {g,p,k}, helper function for one-hot legality.
- One sub-module: gpk_beat_ripple (combinational: c0, g/p/k vectors -> carries, cout, err); top holds FSM, carry register, output stage.

## Test plan
- WIDTH=8, PIPE=1, single beat first+last, g=0x01 p=0xFE k=0x00 cin=0 (0xFF+0x01) -> out_c=0xFE, out_cout=1, out_err=0, out_last=1, one cycle later.
- Two-beat frame: beat0 g=0x80 p=0x00 k=0x7F, beat1 g=0x00 p=0xFF k=0x00 -> beat0 out_c=0x00 cout=1; beat1 out_c=0xFF cout=1; state IDLE after.
- Backpressure: out_ready low 3 cycles with in_valid held -> in_ready low, out_* unchanged all 3 cycles, each beat delivered exactly once after release.
- Illegal encoding: bit0 g=1 p=1, rest p, cin=1 -> bit0 treated as kill, out_c=0x01, out_cout=0, out_err=1.
- Abort/orphan: in_first while BUSY -> out_err=1, c0=cin; non-first beat in IDLE -> out_err=1, c0=0.
- Reset mid-frame after beat0 of a 3-beat frame -> outputs at reset values immediately, next first beat resolves using its cin, not the stale carry.
